// File: rtl/ft_bcd_count_latch.sv
// BCD event counter with gated counting, level clear and edge-triggered result latch.
// All asynchronous controller strobes and FSIN are synchronised onto CLK.
module ft_bcd_count_latch #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FSIN,
  input  logic                  CNT_EN,
  input  logic                  RST_CNT,
  input  logic                  LOAD,
  output logic [4*DIGITS-1:0]   DOUT,
  output logic                  OVF,
  output logic                  VALID
);

  localparam int unsigned W = 4 * DIGITS;

  // Bit order within each stage: {LOAD, RST_CNT, CNT_EN, FSIN}
  logic [3:0] sync_q [SYNC_STAGES];

  logic fsin_s, cnt_en_s, rst_cnt_s, load_s;
  logic fsin_s_d_q, load_s_d_q;
  logic fsin_rise, load_rise;

  logic [W-1:0] cnt_q, cnt_d, cnt_inc;
  logic         ovf_sticky_q, ovf_sticky_d;
  logic         inc_wrap;

  logic [W-1:0] snap_cnt_q;
  logic         snap_ovf_q, snap_vld_q;
  logic [W-1:0] dout_q;
  logic         ovf_q, valid_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'b0000;
      end
    end else begin
      sync_q[0] <= {LOAD, RST_CNT, CNT_EN, FSIN};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign fsin_s    = sync_q[SYNC_STAGES-1][0];
  assign cnt_en_s  = sync_q[SYNC_STAGES-1][1];
  assign rst_cnt_s = sync_q[SYNC_STAGES-1][2];
  assign load_s    = sync_q[SYNC_STAGES-1][3];

  assign fsin_rise = fsin_s & ~fsin_s_d_q;
  assign load_rise = load_s & ~load_s_d_q;

  // Ripple BCD increment: a digit advances only while every lower digit rolls 9 -> 0.
  always_comb begin
    logic carry;
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    inc_wrap = carry;
  end

  always_comb begin
    cnt_d        = cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    if (rst_cnt_s) begin
      cnt_d        = '0;
      ovf_sticky_d = 1'b0;
    end else if (cnt_en_s && fsin_rise) begin
      cnt_d        = cnt_inc;
      ovf_sticky_d = ovf_sticky_q | inc_wrap;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsin_s_d_q   <= 1'b0;
      load_s_d_q   <= 1'b0;
      cnt_q        <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      fsin_s_d_q   <= fsin_s;
      load_s_d_q   <= load_s;
      cnt_q        <= cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  // Snapshot takes the pre-update count; the display register follows one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snap_cnt_q <= '0;
      snap_ovf_q <= 1'b0;
      snap_vld_q <= 1'b0;
      dout_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      snap_vld_q <= load_rise;
      if (load_rise) begin
        snap_cnt_q <= cnt_q;
        snap_ovf_q <= ovf_sticky_q;
      end
      valid_q <= snap_vld_q;
      if (snap_vld_q) begin
        dout_q <= snap_cnt_q;
        ovf_q  <= snap_ovf_q;
      end
    end
  end

  assign DOUT  = dout_q;
  assign OVF   = ovf_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_ft_bcd_count_latch.sv
// Scoreboard bench: an 8-digit and a 2-digit counter share stimulus; an arithmetic
// model predicts every latched result.
module tb_ft_bcd_count_latch;

  logic CLK = 1'b0;
  logic RST, FSIN, CNT_EN, RST_CNT, LOAD;
  logic [31:0] dout8;
  logic [7:0]  dout2;
  logic        ovf8, ovf2, valid8, valid2;

  always #5 CLK = ~CLK;

  ft_bcd_count_latch #(.DIGITS(8), .SYNC_STAGES(2)) dut8 (
    .CLK(CLK), .RST(RST), .FSIN(FSIN), .CNT_EN(CNT_EN), .RST_CNT(RST_CNT), .LOAD(LOAD),
    .DOUT(dout8), .OVF(ovf8), .VALID(valid8)
  );

  ft_bcd_count_latch #(.DIGITS(2), .SYNC_STAGES(2)) dut2 (
    .CLK(CLK), .RST(RST), .FSIN(FSIN), .CNT_EN(CNT_EN), .RST_CNT(RST_CNT), .LOAD(LOAD),
    .DOUT(dout2), .OVF(ovf2), .VALID(valid2)
  );

  typedef struct packed {
    logic [31:0] d8;
    logic        o8;
    logic [7:0]  d2;
    logic        o2;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_loads  = 0;

  int unsigned cnt_m;
  logic        ovf2_m, ovf8_m;
  logic        en_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [31:0] b2;
    e.d8 = to_bcd(cnt_m % 100000000);
    e.o8 = ovf8_m;
    b2   = to_bcd(cnt_m % 100);
    e.d2 = b2[7:0];
    e.o2 = ovf2_m;
    return e;
  endfunction

  function automatic void model_edge();
    if (en_m) begin
      cnt_m++;
      if (cnt_m % 100 == 0) ovf2_m = 1'b1;
      if (cnt_m % 100000000 == 0) ovf8_m = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    cnt_m  = 0;
    ovf2_m = 1'b0;
    ovf8_m = 1'b0;
  endfunction

  always @(negedge CLK) begin
    if (!RST && (valid8 || valid2)) begin
      exp_t e;
      n_valid++;
      check_eq("valid_align", {31'd0, valid2}, {31'd0, valid8});
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("dout8", dout8, e.d8);
        check_eq("ovf8", {31'd0, ovf8}, {31'd0, e.o8});
        check_eq("dout2", {24'd0, dout2}, {24'd0, e.d2});
        check_eq("ovf2", {31'd0, ovf2}, {31'd0, e.o2});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic fsin_edges(input int n);
    for (int k = 0; k < n; k++) begin
      FSIN = 1'b1;
      model_edge();
      wait_cyc(3);
      FSIN = 1'b0;
      wait_cyc(3);
    end
  endtask

  task automatic set_en(input logic v);
    CNT_EN = v;
    en_m   = v;
    wait_cyc(4);
  endtask

  task automatic pulse_rst_cnt();
    RST_CNT = 1'b1;
    model_clear();
    wait_cyc(4);
    RST_CNT = 1'b0;
    wait_cyc(4);
  endtask

  // Raise LOAD, measure latency to VALID, hold LOAD for `hold` cycles total.
  task automatic do_load(input int hold);
    int lat;
    LOAD = 1'b1;
    sb_q.push_back(predict());
    n_loads++;
    lat = 0;
    while (!valid8 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check_eq("load_latency", 32'(lat), 32'd4);
    if (hold > lat) wait_cyc(hold - lat);
    LOAD = 1'b0;
    wait_cyc(4);
  endtask

  initial begin
    int v0;
    RST = 1'b1; FSIN = 1'b0; CNT_EN = 1'b0; RST_CNT = 1'b0; LOAD = 1'b0;
    en_m = 1'b0;
    model_clear();
    // Reset with inputs toggling
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      FSIN = ~FSIN; LOAD = ~LOAD; CNT_EN = ~CNT_EN; RST_CNT = ~RST_CNT;
    end
    check_eq("rst_dout", dout8, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf8}, 32'd0);
    check_eq("rst_valid", {31'd0, valid8}, 32'd0);
    FSIN = 1'b0; LOAD = 1'b0; CNT_EN = 1'b0; RST_CNT = 1'b0;
    wait_cyc(1);
    RST = 1'b0;
    wait_cyc(4);

    // Basic count
    pulse_rst_cnt();
    set_en(1'b1);
    fsin_edges(1234);
    set_en(1'b0);
    do_load(2);

    // BCD carry chain, also overflows the 2-digit counter
    pulse_rst_cnt();
    set_en(1'b1);
    fsin_edges(199);
    do_load(2);
    fsin_edges(1);
    do_load(2);

    // Overflow on exactly 100 edges, then cleared
    pulse_rst_cnt();
    fsin_edges(100);
    do_load(2);
    pulse_rst_cnt();
    fsin_edges(5);
    do_load(2);

    // Gate honour and LOAD held high
    pulse_rst_cnt();
    set_en(1'b0);
    fsin_edges(50);
    set_en(1'b1);
    fsin_edges(7);
    v0 = n_valid;
    do_load(20);
    wait_cyc(4);
    check_eq("held_load_one_valid", 32'(n_valid - v0), 32'd1);

    // RST_CNT and LOAD together: latch pre-clear count
    pulse_rst_cnt();
    fsin_edges(42);
    RST_CNT = 1'b1;
    LOAD    = 1'b1;
    sb_q.push_back(predict());
    n_loads++;
    model_clear();
    wait_cyc(6);
    RST_CNT = 1'b0;
    LOAD    = 1'b0;
    wait_cyc(4);
    do_load(2);

    // LOAD coincident with an FSIN edge: latch pre-increment count
    fsin_edges(9);
    FSIN = 1'b1;
    LOAD = 1'b1;
    sb_q.push_back(predict());
    n_loads++;
    model_edge();
    wait_cyc(3);
    FSIN = 1'b0;
    wait_cyc(3);
    LOAD = 1'b0;
    wait_cyc(4);
    do_load(2);

    // Mid-gate reset
    pulse_rst_cnt();
    fsin_edges(300);
    do_load(2);
    RST = 1'b1;
    model_clear();
    #1;
    check_eq("midrst_dout8", dout8, 32'd0);
    check_eq("midrst_ovf2", {31'd0, ovf2}, 32'd0);
    check_eq("midrst_valid", {31'd0, valid8}, 32'd0);
    wait_cyc(1);
    RST = 1'b0;
    wait_cyc(4);
    fsin_edges(10);
    do_load(2);

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge CLK);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    check_eq("valid_count", 32'(n_valid), 32'(n_loads));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
